// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int unsigned REG_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned PC_REG    = 15;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: memory stage beats writeback, R15 never forwarded.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] wa_m_i,
    input  logic             regwrite_m_i,
    input  logic             memtoreg_m_i,
    input  logic [REG_W-1:0] wa_w_i,
    input  logic             regwrite_w_i,
    output logic [1:0]       fwd_o
);

    logic not_pc;

    // A load in M has no data yet, so it is skipped on the memory path.
    always_comb begin
        fwd_o  = FWD_RF;
        not_pc = (src_i != REG_W'(PC_REG));
        if (not_pc && regwrite_m_i && !memtoreg_m_i && (wa_m_i == src_i)) begin
            fwd_o = FWD_MEM;
        end else if (not_pc && regwrite_w_i && (wa_w_i == src_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: tracks M/W stages, resolves load-use stalls,
// branch flushes and operand forwarding, and counts stall/flush events.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA3D,
    input  logic             UseAD,
    input  logic             UseBD,
    input  logic             UseCD,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] RA3E,
    input  logic [REG_W-1:0] WA3E,
    input  logic             RegWriteE,
    input  logic             MemToRegE,
    input  logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [1:0]       ForwardCE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    logic [REG_W-1:0] wa3_m_q, wa3_w_q;
    logic             regwrite_m_q, memtoreg_m_q, regwrite_w_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       ld_stall, br_flush;
    logic [1:0] fwd_a, fwd_b, fwd_c;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src_i(RA1E), .wa_m_i(wa3_m_q), .regwrite_m_i(regwrite_m_q),
        .memtoreg_m_i(memtoreg_m_q), .wa_w_i(wa3_w_q), .regwrite_w_i(regwrite_w_q),
        .fwd_o(fwd_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src_i(RA2E), .wa_m_i(wa3_m_q), .regwrite_m_i(regwrite_m_q),
        .memtoreg_m_i(memtoreg_m_q), .wa_w_i(wa3_w_q), .regwrite_w_i(regwrite_w_q),
        .fwd_o(fwd_b)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_c (
        .src_i(RA3E), .wa_m_i(wa3_m_q), .regwrite_m_i(regwrite_m_q),
        .memtoreg_m_i(memtoreg_m_q), .wa_w_i(wa3_w_q), .regwrite_w_i(regwrite_w_q),
        .fwd_o(fwd_c)
    );

    // Hazard detection and control outputs; a taken branch overrides the stall
    // because the decode-stage instruction is on the wrong path.
    always_comb begin
        ld_stall = RegWriteE && MemToRegE && (WA3E != REG_W'(PC_REG)) &&
                   ((UseAD && (RA1D == WA3E)) ||
                    (UseBD && (RA2D == WA3E)) ||
                    (UseCD && (RA3D == WA3E)));
        br_flush = PCSrcE;

        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardCE = FWD_RF;
        if (!rst) begin
            StallF    = ld_stall && !br_flush;
            StallD    = ld_stall && !br_flush;
            FlushD    = br_flush;
            FlushE    = ld_stall || br_flush;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            ForwardCE = fwd_c;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa3_m_q      <= '0;
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            wa3_w_q      <= '0;
            regwrite_w_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            wa3_m_q      <= WA3E;
            regwrite_m_q <= RegWriteE;
            memtoreg_m_q <= MemToRegE;
            wa3_w_q      <= wa3_m_q;
            regwrite_w_q <= regwrite_m_q;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] RA1D, RA2D, RA3D, RA1E, RA2E, RA3E, WA3E;
    logic       UseAD, UseBD, UseCD, RegWriteE, MemToRegE, PCSrcE;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE, ForwardCE;
    logic [15:0] StallCnt, FlushCnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_flush = 16'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D),
        .UseAD(UseAD), .UseBD(UseBD), .UseCD(UseCD),
        .RA1E(RA1E), .RA2E(RA2E), .RA3E(RA3E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RA1D = 4'd0; RA2D = 4'd0; RA3D = 4'd0;
        UseAD = 1'b0; UseBD = 1'b0; UseCD = 1'b0;
        RA1E = 4'd0; RA2E = 4'd0; RA3E = 4'd0; WA3E = 4'd0;
        RegWriteE = 1'b0; MemToRegE = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic drain();
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        RegWriteE = 1'b1; WA3E = 4'd3; RA1E = 4'd3;
        #1;
        checks++; if ({FlushD, FlushE} !== 2'b11) begin errors++; $display("FAIL rst_flush: got %b want 11", {FlushD, FlushE}); end
        checks++; if ({StallF, StallD} !== 2'b00) begin errors++; $display("FAIL rst_stall: got %b want 00", {StallF, StallD}); end
        cyc();
        cyc();
        checks++; if ({ForwardAE, ForwardBE, ForwardCE} !== 6'b0) begin errors++; $display("FAIL rst_fwd: got %b want 000000", {ForwardAE, ForwardBE, ForwardCE}); end
        rst = 1'b0;
        #1;
        checks++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0000/0000", StallCnt, FlushCnt); end
        checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL rst_release_flushd: got %b want 0", FlushD); end
        cyc();
        RegWriteE = 1'b0; WA3E = 4'd0;
        #1;
        checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL rst_fwd_mem: got %b want 10", ForwardAE); end
        cyc();
        checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL rst_fwd_wb: got %b want 01", ForwardAE); end
    endtask

    task automatic test_forward_alu();
        drain();
        RegWriteE = 1'b1; WA3E = 4'd2;
        cyc();
        RegWriteE = 1'b0; WA3E = 4'd0; RA1E = 4'd2; RA2E = 4'd2; RA3E = 4'd9;
        #1;
        checks++; if ({ForwardAE, ForwardBE, ForwardCE} !== 6'b10_10_00) begin errors++; $display("FAIL alu_fwd_mem: got %b want 101000", {ForwardAE, ForwardBE, ForwardCE}); end
        cyc();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b01_01) begin errors++; $display("FAIL alu_fwd_wb: got %b want 0101", {ForwardAE, ForwardBE}); end
        cyc();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b00_00) begin errors++; $display("FAIL alu_fwd_gone: got %b want 0000", {ForwardAE, ForwardBE}); end
    endtask

    task automatic test_load_use();
        drain();
        RegWriteE = 1'b1; MemToRegE = 1'b1; WA3E = 4'd4;
        UseBD = 1'b1; RA2D = 4'd4;
        #1;
        checks++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin errors++; $display("FAIL lu_stall: got %b want 1110", {StallF, StallD, FlushE, FlushD}); end
        cyc();
        exp_stall = exp_stall + 16'd1;
        RegWriteE = 1'b0; MemToRegE = 1'b0; WA3E = 4'd0;
        #1;
        checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL lu_one_bubble: got %b want 000", {StallF, StallD, FlushE}); end
        checks++; if (StallCnt !== exp_stall) begin errors++; $display("FAIL lu_cnt: got %h want %h", StallCnt, exp_stall); end
        cyc();
        UseBD = 1'b0; RA2D = 4'd0;
        RA2E = 4'd4; RegWriteE = 1'b1; WA3E = 4'd5;
        #1;
        checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL lu_fwd_wb: got %b want 01", ForwardBE); end
    endtask

    task automatic test_branch_over_load();
        drain();
        RegWriteE = 1'b1; MemToRegE = 1'b1; WA3E = 4'd4;
        UseBD = 1'b1; RA2D = 4'd4; PCSrcE = 1'b1;
        #1;
        checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin errors++; $display("FAIL br_ctrl: got %b want 0011", {StallF, StallD, FlushD, FlushE}); end
        cyc();
        exp_flush = exp_flush + 16'd1;
        idle();
        #1;
        checks++; if (FlushCnt !== exp_flush || StallCnt !== exp_stall) begin errors++; $display("FAIL br_cnt: got %h/%h want %h/%h", FlushCnt, StallCnt, exp_flush, exp_stall); end
    endtask

    task automatic test_r15();
        drain();
        RegWriteE = 1'b1; WA3E = 4'd15;
        cyc();
        idle();
        RA1E = 4'd15;
        #1;
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL r15_mem: got %b want 00", ForwardAE); end
        cyc();
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL r15_wb: got %b want 00", ForwardAE); end
        RegWriteE = 1'b1; MemToRegE = 1'b1; WA3E = 4'd15; UseAD = 1'b1; RA1D = 4'd15;
        #1;
        checks++; if ({StallF, FlushE} !== 2'b00) begin errors++; $display("FAIL r15_load: got %b want 00", {StallF, FlushE}); end
    endtask

    task automatic test_back_to_back();
        drain();
        // Load in M must not be forwarded from the memory stage.
        RegWriteE = 1'b1; MemToRegE = 1'b1; WA3E = 4'd6;
        cyc();
        idle();
        RA1E = 4'd6;
        #1;
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL load_in_m: got %b want 00", ForwardAE); end
        drain();
        RegWriteE = 1'b1; WA3E = 4'd7;
        cyc();
        cyc();
        idle();
        RA1E = 4'd7; RA3E = 4'd7;
        #1;
        checks++; if ({ForwardAE, ForwardCE} !== 4'b10_10) begin errors++; $display("FAIL m_over_w: got %b want 1010", {ForwardAE, ForwardCE}); end
    endtask

    task automatic test_saturation();
        drain();
        RegWriteE = 1'b1; MemToRegE = 1'b1; WA3E = 4'd4; UseCD = 1'b1; RA3D = 4'd4;
        repeat (65541) cyc();
        checks++; if (StallCnt !== 16'hFFFF) begin errors++; $display("FAIL sat_stall: got %h want ffff", StallCnt); end
        checks++; if (FlushCnt !== exp_flush) begin errors++; $display("FAIL sat_flush_hold: got %h want %h", FlushCnt, exp_flush); end
        rst = 1'b1;
        #1;
        checks++; if ({StallF, FlushD, FlushE} !== 3'b011) begin errors++; $display("FAIL sat_rst_ctrl: got %b want 011", {StallF, FlushD, FlushE}); end
        cyc();
        rst = 1'b0;
        idle();
        RA1E = 4'd4;
        #1;
        checks++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin errors++; $display("FAIL sat_rst_cnt: got %h/%h want 0000/0000", StallCnt, FlushCnt); end
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL sat_rst_stale: got %b want 00", ForwardAE); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_forward_alu();
        test_load_use();
        test_branch_over_load();
        test_r15();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
